// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and widths for the writeback trace buffer
package trace_pkg;

    localparam int TRACE_XLEN   = 32;
    localparam int TRACE_REG_AW = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        POST    = 2'd2,
        DONE    = 2'd3
    } trace_state_t;

    typedef struct packed {
        logic [TRACE_XLEN-1:0]   pc;
        logic [TRACE_REG_AW-1:0] rd;
        logic [TRACE_XLEN-1:0]   data;
    } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - trace entry storage, synchronous write, asynchronous read
module trace_ram
    import trace_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk_i,
    input  logic         we_i,
    input  logic [AW-1:0] waddr_i,
    input  trace_entry_t wdata_i,
    input  logic [AW-1:0] raddr_i,
    output trace_entry_t rdata_o
);

    trace_entry_t mem_q [DEPTH];

    // Contents are deliberately not reset; count/pointers define validity.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipeline_trace_buffer.sv
// rtl/pipeline_trace_buffer.sv - writeback trace buffer; optional PC trigger under TRACE_TRIGGER_EN
module pipeline_trace_buffer
    import trace_pkg::*;
#(
    parameter int XLEN      = TRACE_XLEN,
    parameter int REG_AW    = TRACE_REG_AW,
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     wb_valid,
    input  logic                     wb_we,
    input  logic [XLEN-1:0]          wb_pc,
    input  logic [REG_AW-1:0]        wb_rd,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     cfg_mode,
    input  logic                     arm,
    input  logic                     stop,
`ifdef TRACE_TRIGGER_EN
    input  logic [XLEN-1:0]          trig_pc,
`endif
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [XLEN-1:0]          rd_pc,
    output logic [REG_AW-1:0]        rd_rd,
    output logic [XLEN-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [1:0]               state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    trace_state_t  state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] post_cnt_q, post_cnt_d;
    logic          overflow_q, overflow_d;

    logic          qual, full, in_cap, wr_en, pop, trig_hit, post_last, fill_end;
    trace_entry_t  wr_entry, rd_entry;

    assign qual   = wb_valid & wb_we & (wb_rd != '0);
    assign full   = (count_q == FULL);
    assign in_cap = (state_q == CAPTURE) || (state_q == POST);
    // arm restarts capture, so an event arriving with it is dropped.
    assign wr_en  = in_cap & ~arm & qual & ~(cfg_mode & full);
    assign pop    = (state_q == DONE) & ~arm & (count_q != '0) & rd_ready;

`ifdef TRACE_TRIGGER_EN
    assign trig_hit = wr_en & (state_q == CAPTURE) & (wb_pc == trig_pc);
`else
    assign trig_hit = 1'b0;
`endif

    // The trigger entry itself is not part of the POST_TRIG window.
    assign post_last = (state_q == POST) & wr_en & (post_cnt_q == PW'(POST_TRIG - 1));
    // Stop-when-full ends on the write that fills the buffer (or if already full).
    assign fill_end  = in_cap & ~arm & cfg_mode & (full | (wr_en & (count_q == FULL - 1'b1)));

    assign wr_entry.pc   = wb_pc;
    assign wr_entry.rd   = wb_rd;
    assign wr_entry.data = wb_data;

    trace_ram #(
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            post_cnt_q <= post_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state selection; arm beats stop, stop/full beats trigger.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (arm) state_d = CAPTURE;
            end
            CAPTURE, POST: begin
                if (arm)                               state_d = CAPTURE;
                else if (stop || fill_end || post_last) state_d = DONE;
                else if (trig_hit)                     state_d = POST;
            end
            DONE: begin
                if (arm)                                      state_d = CAPTURE;
                else if ((count_q == '0) || (pop && count_q == CW'(1))) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer, occupancy and overflow updates for writes, pops and restarts.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        post_cnt_d = post_cnt_q;
        overflow_d = overflow_q;
        if (arm) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            post_cnt_d = '0;
            overflow_d = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (full) begin
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
                if (state_q == POST) post_cnt_d = post_cnt_q + 1'b1;
            end
            if (trig_hit) post_cnt_d = '0;
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                count_d  = count_q - 1'b1;
            end
        end
    end

    // Readout port: oldest entry, zeroed whenever nothing is offered.
    always_comb begin
        rd_valid = (state_q == DONE) && (count_q != '0);
        rd_pc    = '0;
        rd_rd    = '0;
        rd_data  = '0;
        if (rd_valid) begin
            rd_pc   = rd_entry.pc;
            rd_rd   = rd_entry.rd;
            rd_data = rd_entry.data;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;
    assign state    = state_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// tb/tb_pipeline_trace_buffer.sv - scoreboard bench for pipeline_trace_buffer
module tb_pipeline_trace_buffer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        wb_valid = 1'b0;
    logic        wb_we = 1'b0;
    logic [31:0] wb_pc = '0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        cfg_mode = 1'b0;
    logic        arm = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] trig_pc = 32'h40;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_pc;
    logic [4:0]  rd_rd;
    logic [31:0] rd_data;
    logic [3:0]  count;
    logic        overflow;
    logic [1:0]  state;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    pipeline_trace_buffer #(
        .XLEN(32), .REG_AW(5), .DEPTH(8), .POST_TRIG(3)
    ) dut (
        .CLK(CLK), .RST(RST),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data),
        .cfg_mode(cfg_mode), .arm(arm), .stop(stop),
`ifdef TRACE_TRIGGER_EN
        .trig_pc(trig_pc),
`endif
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_rd(rd_rd), .rd_data(rd_data),
        .count(count), .overflow(overflow), .state(state)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: peek during stalls, pop on accepted handshakes.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST && rd_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rd_valid", 64'(rd_valid), 64'd0);
                end else begin
                    check("rd_pc",   64'(rd_pc),   64'(sb[0].pc));
                    check("rd_rd",   64'(rd_rd),   64'(sb[0].rd));
                    check("rd_data", 64'(rd_data), 64'(sb[0].data));
                    if (rd_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic ev(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data,
                      input logic v, input logic we, input logic st);
        wb_valid = v; wb_we = we; wb_pc = pc; wb_rd = rd; wb_data = data; stop = st;
        tick(1);
        wb_valid = 1'b0; wb_we = 1'b0; stop = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.pc = pc; e.rd = rd; e.data = data;
        sb.push_back(e);
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic readout(input bit toggle);
        int k = 0;
        while (state != 2'd0 && k < 100) begin
            rd_ready = toggle ? pat[k % 4] : 1'b1;
            k++;
            tick(1);
        end
        rd_ready = 1'b0;
        check("readout_reaches_idle", 64'(state), 64'd0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1 RST = 1'b1;
        #2;
        check("reset_state", 64'(state), 64'd0);
        check("reset_count", 64'(count), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        check("reset_rd_valid", 64'(rd_valid), 64'd0);
        check("reset_rd_pc", 64'(rd_pc), 64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        tick(1);

        // Mode 1: stop when full after 8 of 10 events.
        cfg_mode = 1'b1;
        arm_pulse();
        check("a_state_capture", 64'(state), 64'd1);
        for (int i = 1; i <= 10; i++) begin
            if (i <= 8) push(32'h1000 + 32'(4 * i), 5'(i), 32'h100 + 32'(i));
            ev(32'h1000 + 32'(4 * i), 5'(i), 32'h100 + 32'(i), 1'b1, 1'b1, 1'b0);
            if (i == 8) begin
                check("a_state_done_at_full", 64'(state), 64'd3);
                check("a_count_full", 64'(count), 64'd8);
            end
        end
        check("a_count_after_extra", 64'(count), 64'd8);
        check("a_overflow", 64'(overflow), 64'd0);
        readout(1'b0);

        // Mode 0: wrap, 11 events then stop; entries 4..11 survive.
        cfg_mode = 1'b0;
        arm_pulse();
        for (int i = 1; i <= 11; i++) begin
            if (i >= 4) push(32'h2000 + 32'(4 * i), 5'(i), 32'h200 + 32'(i));
            ev(32'h2000 + 32'(4 * i), 5'(i), 32'h200 + 32'(i), 1'b1, 1'b1, 1'b0);
        end
        stop = 1'b1; tick(1); stop = 1'b0;
        check("b_state_done", 64'(state), 64'd3);
        check("b_count", 64'(count), 64'd8);
        check("b_overflow", 64'(overflow), 64'd1);
        readout(1'b1);

        // Non-qualifying events are skipped; event with stop is still recorded.
        arm_pulse();
        push(32'h3000, 5'd3, 32'hA3);
        ev(32'h3000, 5'd3, 32'hA3, 1'b1, 1'b1, 1'b0);
        ev(32'h3004, 5'd0, 32'hA0, 1'b1, 1'b1, 1'b0);
        push(32'h3008, 5'd5, 32'hA5);
        ev(32'h3008, 5'd5, 32'hA5, 1'b1, 1'b1, 1'b0);
        ev(32'h300C, 5'd7, 32'hA7, 1'b1, 1'b0, 1'b0);
        ev(32'h3010, 5'd9, 32'hA9, 1'b0, 1'b1, 1'b0);
        push(32'h3014, 5'd10, 32'hAA);
        ev(32'h3014, 5'd10, 32'hAA, 1'b1, 1'b1, 1'b1);
        check("c_state_done", 64'(state), 64'd3);
        check("c_count_qualifying", 64'(count), 64'd3);
        readout(1'b1);

`ifdef TRACE_TRIGGER_EN
        // Trigger at 0x40 followed by exactly three post-trigger entries.
        arm_pulse();
        push(32'h10, 5'd1, 32'h11); ev(32'h10, 5'd1, 32'h11, 1'b1, 1'b1, 1'b0);
        push(32'h20, 5'd2, 32'h22); ev(32'h20, 5'd2, 32'h22, 1'b1, 1'b1, 1'b0);
        push(32'h40, 5'd3, 32'h33); ev(32'h40, 5'd3, 32'h33, 1'b1, 1'b1, 1'b0);
        check("d_state_post", 64'(state), 64'd2);
        for (int i = 1; i <= 5; i++) begin
            if (i <= 3) push(32'h40 + 32'(4 * i), 5'(3 + i), 32'h40 + 32'(i));
            ev(32'h40 + 32'(4 * i), 5'(3 + i), 32'h40 + 32'(i), 1'b1, 1'b1, 1'b0);
        end
        check("d_state_done", 64'(state), 64'd3);
        check("d_count", 64'(count), 64'd6);
        readout(1'b0);
`endif

        // arm together with stop: arm wins.
        arm = 1'b1; stop = 1'b1; tick(1); arm = 1'b0; stop = 1'b0;
        check("e_arm_beats_stop", 64'(state), 64'd1);

        // Asynchronous reset mid-capture.
        arm_pulse();
        for (int i = 1; i <= 5; i++) ev(32'h5000 + 32'(4 * i), 5'(i), 32'(i), 1'b1, 1'b1, 1'b0);
        check("f_count_before_reset", 64'(count), 64'd5);
        #2 RST = 1'b1;
        #1;
        check("f_async_count", 64'(count), 64'd0);
        check("f_async_state", 64'(state), 64'd0);
        check("f_async_rd_valid", 64'(rd_valid), 64'd0);
        #1 RST = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
